// File: rtl/nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial adder.
// One nibble width, one FSM state type.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle.
// master drives operands, slave returns results.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );

endinterface

// File: rtl/nibble_serial_adder_fa4.sv
// 4-bit ripple-carry adder built from
// explicit xor/and/or full-adder cells.
module full_adder_4
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W:0] c;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign p[i]   = a[i] ^ b[i];
    assign g[i]   = a[i] & b[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per cycle,
// LSB first, through a single 4-bit adder.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NIBBLES - 1);
  localparam int CAT_W = WIDTH + NIBBLE_W;

  if ((WIDTH % NIBBLE_W) != 0 ||
      WIDTH < NIBBLE_W) begin : g_bad_width
    $error("WIDTH must be a multiple of 4, >= 4");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [NIBBLE_W-1:0] add_s;
  logic                add_co;
  logic [CAT_W-1:0]    sum_cat;

  full_adder_4 u_fa4 (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // New nibble enters the sum from the top.
  assign sum_cat = {add_s, sum_q};

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = BUSY;
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      BUSY: begin
        sum_d   = sum_cat[CAT_W-1:NIBBLE_W];
        carry_d = add_co;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          cout_d      = add_co;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers, sync reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder, WIDTH=16 and 4.
// Checks against plain a+b+cin arithmetic.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) b16 ();
  nibble_serial_adder_if #(.WIDTH(4))  b4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16.slave)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  function automatic void ref_add(
    input  int          w,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        co
  );
    longint t;
    longint m;
    m  = (longint'(1) << w) - 1;
    t  = (longint'(a) & m) + (longint'(b) & m)
       + longint'(cin);
    s  = 16'(t & m);
    co = ((t >> w) & 1) != 0;
  endfunction

  function automatic logic [15:0] got_sum(bit w4);
    return w4 ? 16'(b4.sum) : b16.sum;
  endfunction

  function automatic logic got_cout(bit w4);
    return w4 ? b4.cout : b16.cout;
  endfunction

  function automatic logic got_ov(bit w4);
    return w4 ? b4.out_valid : b16.out_valid;
  endfunction

  function automatic logic got_ir(bit w4);
    return w4 ? b4.in_ready : b16.in_ready;
  endfunction

  // Present one pair; returns at the negedge
  // following the accepting edge.
  task automatic issue(
    input bit          w4,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        cin
  );
    int n = 0;
    while (!got_ir(w4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout in_ready=0");
    end
    if (w4) begin
      b4.a = a[3:0];
      b4.b = b[3:0];
      b4.cin = cin;
      b4.in_valid = 1'b1;
    end else begin
      b16.a = a;
      b16.b = b;
      b16.cin = cin;
      b16.in_valid = 1'b1;
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    b16.in_valid = 1'b0;
  endtask

  task automatic wait_result(
    input  bit w4,
    output int lat
  );
    lat = 0;
    while (!got_ov(w4) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      tests++;
      fails++;
      $display("FAIL result_timeout out_valid=0");
    end
  endtask

  task automatic ack(input bit w4);
    if (w4) b4.out_ready = 1'b1;
    else b16.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
    b16.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit w4 = (k == 1);
      tests++;
      if (got_sum(w4) !== 16'h0 ||
          got_cout(w4) !== 1'b0 ||
          got_ov(w4) !== 1'b0 ||
          got_ir(w4) !== 1'b1) begin
        fails++;
        $display("FAIL reset w4=%0d got s=%h c=%b v=%b r=%b want 0 0 0 1",
                 w4, got_sum(w4), got_cout(w4),
                 got_ov(w4), got_ir(w4));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] ta [2] = '{16'h1234, 16'hFFFF};
    logic [15:0] tb [2] = '{16'h4321, 16'h0001};
    logic [15:0] es;
    logic        ec;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      ref_add(16, ta[i], tb[i], 1'b0, es, ec);
      issue(1'b0, ta[i], tb[i], 1'b0);
      wait_result(1'b0, lat);
      tests++;
      if (lat != 4) begin
        fails++;
        $display("FAIL latency16 got %0d want 4", lat);
      end
      tests++;
      if (b16.sum !== es || b16.cout !== ec) begin
        fails++;
        $display("FAIL directed%0d got %b_%h want %b_%h",
                 i, b16.cout, b16.sum, ec, es);
      end
      ack(1'b0);
    end
  endtask

  task automatic test_hold;
    logic [15:0] es;
    logic        ec;
    int          lat;
    bit          bad = 0;
    ref_add(16, 16'hFFFF, 16'hFFFF, 1'b1, es, ec);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_result(1'b0, lat);
    tests++;
    if (b16.sum !== es || b16.cout !== ec) begin
      fails++;
      $display("FAIL all_ones got %b_%h want %b_%h",
               b16.cout, b16.sum, ec, es);
    end
    repeat (5) begin
      @(negedge clk);
      if (b16.out_valid !== 1'b1 ||
          b16.sum !== es || b16.cout !== ec ||
          b16.in_ready !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL hold_stable got v=%b s=%h want v=1 s=%h",
               b16.out_valid, b16.sum, es);
    end
    ack(1'b0);
    tests++;
    if (b16.out_valid !== 1'b0 ||
        b16.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL release got v=%b r=%b want v=0 r=1",
               b16.out_valid, b16.in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] es1, es2;
    logic        ec1, ec2;
    int          lat = 0;
    bit          bad = 0;
    ref_add(16, 16'h1111, 16'h2222, 1'b0, es1, ec1);
    ref_add(16, 16'h0F0F, 16'h00F1, 1'b0, es2, ec2);
    b16.a = 16'h1111;
    b16.b = 16'h2222;
    b16.cin = 1'b0;
    b16.in_valid = 1'b1;
    @(negedge clk);
    b16.a = 16'h0F0F;
    b16.b = 16'h00F1;
    while (!b16.out_valid && lat < 50) begin
      if (b16.in_ready !== 1'b0) bad = 1;
      @(negedge clk);
      lat++;
    end
    tests++;
    if (bad || lat != 4) begin
      fails++;
      $display("FAIL b2b_busy got lat=%0d bad=%0d want 4 0",
               lat, bad);
    end
    tests++;
    if (b16.sum !== es1 || b16.cout !== ec1) begin
      fails++;
      $display("FAIL b2b_first got %b_%h want %b_%h",
               b16.cout, b16.sum, ec1, es1);
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    b16.out_ready = 1'b0;
    tests++;
    if (b16.in_ready !== 1'b1 ||
        b16.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got r=%b v=%b want 1 0",
               b16.in_ready, b16.out_valid);
    end
    @(negedge clk);
    b16.in_valid = 1'b0;
    wait_result(1'b0, lat);
    tests++;
    if (lat != 4 || b16.sum !== es2 ||
        b16.cout !== ec2) begin
      fails++;
      $display("FAIL b2b_second got lat=%0d %b_%h want 4 %b_%h",
               lat, b16.cout, b16.sum, ec2, es2);
    end
    ack(1'b0);
  endtask

  task automatic test_reset_abort;
    int lat;
    bit seen = 0;
    issue(1'b0, 16'hAAAA, 16'h5555, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (b16.sum !== 16'h0 || b16.cout !== 1'b0 ||
        b16.out_valid !== 1'b0 ||
        b16.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_reset got s=%h c=%b v=%b r=%b want 0 0 0 1",
               b16.sum, b16.cout, b16.out_valid,
               b16.in_ready);
    end
    repeat (8) begin
      @(negedge clk);
      if (b16.out_valid) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_pulse got out_valid=1 want 0");
    end
    issue(1'b0, 16'h0001, 16'h0001, 1'b0);
    wait_result(1'b0, lat);
    tests++;
    if (b16.sum !== 16'h0002 || b16.cout !== 1'b0) begin
      fails++;
      $display("FAIL after_abort got %b_%h want 0_0002",
               b16.cout, b16.sum);
    end
    ack(1'b0);
  endtask

  task automatic test_width4;
    logic [15:0] es;
    logic        ec;
    logic [15:0] ra, rb;
    logic        rc;
    int          lat;
    int          nbad = 0;
    issue(1'b1, 16'hF, 16'h1, 1'b1);
    wait_result(1'b1, lat);
    tests++;
    if (lat != 1 || b4.sum !== 4'h1 ||
        b4.cout !== 1'b1) begin
      fails++;
      $display("FAIL w4_directed got lat=%0d %b_%h want 1 1_1",
               lat, b4.cout, b4.sum);
    end
    ack(1'b1);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      ref_add(4, ra, rb, rc, es, ec);
      issue(1'b1, ra, rb, rc);
      wait_result(1'b1, lat);
      tests++;
      if (lat != 1 || got_sum(1'b1) !== es ||
          b4.cout !== ec) begin
        fails++;
        if (nbad++ < 10)
          $display("FAIL w4_rand %h+%h+%b got lat=%0d %b_%h want %b_%h",
                   ra, rb, rc, lat, b4.cout, b4.sum,
                   ec, es);
      end
      ack(1'b1);
    end
  endtask

  task automatic test_random16;
    logic [15:0] es;
    logic        ec;
    logic [15:0] ra, rb;
    logic        rc;
    int          lat;
    int          nbad = 0;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      ref_add(16, ra, rb, rc, es, ec);
      issue(1'b0, ra, rb, rc);
      wait_result(1'b0, lat);
      tests++;
      if (lat != 4 || b16.sum !== es ||
          b16.cout !== ec) begin
        fails++;
        if (nbad++ < 10)
          $display("FAIL w16_rand %h+%h+%b got lat=%0d %b_%h want %b_%h",
                   ra, rb, rc, lat, b16.cout, b16.sum,
                   ec, es);
      end
      ack(1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b16.in_valid = 1'b0;
    b16.a = '0;
    b16.b = '0;
    b16.cin = 1'b0;
    b16.out_ready = 1'b0;
    b4.in_valid = 1'b0;
    b4.a = '0;
    b4.b = '0;
    b4.cin = 1'b0;
    b4.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_width4();
    test_random16();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
